// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 4-digit 7-segment display blocks.
package seg_disp_pkg;

  localparam int unsigned FRAME_W   = 28;
  localparam logic [6:0]  BLANK_SEG = 7'h7F;
  localparam logic [3:0]  AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot divider: one-cycle tick every SCAN_DIV clocks, at count SCAN_DIV-1.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 200000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-source req/gnt arbiter for a shared 4-digit 7-segment display; owns digit
// scanning and only hands over ownership at scan-frame boundaries.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 200000,
  parameter int unsigned HOLD_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [FRAME_W-1:0] frame0,
  input  logic [3:0]         dp0,
  input  logic               req1,
  input  logic [FRAME_W-1:0] frame1,
  input  logic [3:0]         dp1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [3:0]         an
);

  localparam int unsigned HW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

  logic               w_tick, w_boundary, w_hold_sat;
  logic [1:0]         r_ptr, w_nptr;
  state_t             r_state, w_state_nxt, w_src_state;
  logic [HW-1:0]      r_hold, w_hold_nxt;
  logic               r_last, w_last_nxt;
  logic [FRAME_W-1:0] r_fb, w_fb_nxt, w_src_fb;
  logic [3:0]         r_fdp, w_fdp_nxt, w_src_dp;
  logic               r_gnt0, r_gnt1, r_dp;
  logic [6:0]         r_seg;
  logic [3:0]         r_an;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_boundary = w_tick && (r_ptr == 2'd3);
  assign w_nptr     = r_ptr + 2'd1;
  assign w_hold_sat = (r_hold == HOLD_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (req0 && req1) w_state_nxt = r_last ? OWN0 : OWN1;
        else if (req0)    w_state_nxt = OWN0;
        else if (req1)    w_state_nxt = OWN1;
      end
      OWN0: begin
        if (req0) begin
          if (req1 && w_hold_sat) w_state_nxt = OWN1;
          else if (!w_hold_sat)   w_hold_nxt  = r_hold + 1'b1;
        end else begin
          w_state_nxt = req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (req1) begin
          if (req0 && w_hold_sat) w_state_nxt = OWN0;
          else if (!w_hold_sat)   w_hold_nxt  = r_hold + 1'b1;
        end else begin
          w_state_nxt = req0 ? OWN0 : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state) begin
      w_hold_nxt = '0;
      if (w_state_nxt != IDLE) w_last_nxt = (w_state_nxt == OWN1);
    end
    w_fb_nxt  = (w_state_nxt == OWN1) ? frame1 : frame0;
    w_fdp_nxt = (w_state_nxt == OWN1) ? dp1 : dp0;
    // On a boundary the latch is being refilled this edge, so digit0 comes from the live frame.
    w_src_state = w_boundary ? w_state_nxt : r_state;
    w_src_fb    = w_boundary ? w_fb_nxt : r_fb;
    w_src_dp    = w_boundary ? w_fdp_nxt : r_fdp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_last  <= 1'b1;
      r_ptr   <= '0;
      r_fb    <= '0;
      r_fdp   <= '1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_an    <= AN_OFF;
      r_seg   <= BLANK_SEG;
      r_dp    <= 1'b1;
    end else begin
      if (w_tick) begin
        r_ptr <= w_nptr;
        if (w_src_state == IDLE) begin
          r_an  <= AN_OFF;
          r_seg <= BLANK_SEG;
          r_dp  <= 1'b1;
        end else begin
          r_an  <= ~(4'b0001 << w_nptr);
          r_seg <= w_src_fb[7*w_nptr +: 7];
          r_dp  <= w_src_dp[w_nptr];
        end
      end
      if (w_boundary) begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
        r_last  <= w_last_nxt;
        r_fb    <= w_fb_nxt;
        r_fdp   <= w_fdp_nxt;
        r_gnt0  <= (w_state_nxt == OWN0);
        r_gnt1  <= (w_state_nxt == OWN1);
      end
    end
  end

  assign gnt0 = r_gnt0;
  assign gnt1 = r_gnt1;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign an   = r_an;

endmodule
